// File: rtl/route_sched.sv
// route_sched: per-layer route sequencer and IFM aux-port arbiter.
// One route descriptor is taken per layer. The block sequences an optional
// route-buffer load, then holds the route save window until the layer
// finishes. It also shares the IFM aux write port between route reads and
// the DMA fill path on a cycle-by-cycle basis.
module route_sched #(
    parameter int IFM_AW       = 12,
    parameter int W_FRAME_SIZE = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    cfg_vld,
    output logic                    cfg_rdy,
    input  logic                    cfg_save,
    input  logic                    cfg_load,
    input  logic [1:0]              cfg_loc,
    input  logic [IFM_AW-1:0]       cfg_offset,
    input  logic [W_FRAME_SIZE-1:0] cfg_frame_size,
    input  logic                    layer_done,
    input  logic                    pp_data_vld,
    output logic                    q_route_save,
    output logic                    q_route_load,
    output logic [1:0]              q_route_loc,
    output logic [IFM_AW-1:0]       q_route_offset,
    output logic [W_FRAME_SIZE-1:0] q_frame_size,
    output logic                    rte_buf_load_vld,
    input  logic                    rte_buf_load_done,
    input  logic                    dma_aux_req,
    output logic                    dma_aux_gnt,
    output logic                    route_busy,
    output logic                    route_done,
    output logic                    route_err
);

    // Route buffer depth in words; saving more than this into BUF overflows it.
    localparam logic [W_FRAME_SIZE-1:0] SAVE_LIMIT = W_FRAME_SIZE'(512);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECIDE = 3'd1,
        S_LOAD   = 3'd2,
        S_LWAIT  = 3'd3,
        S_SAVE   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Saturating increment: counters stick at all-ones instead of wrapping.
    function automatic logic [W_FRAME_SIZE-1:0] sat_inc(
        input logic [W_FRAME_SIZE-1:0] v,
        input logic                    en
    );
        if (en && (v != {W_FRAME_SIZE{1'b1}})) begin
            return v + W_FRAME_SIZE'(1);
        end else begin
            return v;
        end
    endfunction

    state_t                  r_state;
    logic                    r_cfg_rdy;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_route_save;
    logic                    r_route_load;
    logic                    r_save_flag;
    logic                    r_load_flag;
    logic [1:0]              r_loc;
    logic [IFM_AW-1:0]       r_offset;
    logic [W_FRAME_SIZE-1:0] r_frame_size;
    logic [W_FRAME_SIZE-1:0] r_issue_cnt;
    logic [W_FRAME_SIZE-1:0] r_save_cnt;
    // 1 = DMA won the most recent contended cycle, 0 = route won it.
    logic                    r_last_dma;

    logic                    w_rte_req;
    logic                    w_conflict;
    logic                    w_rte_gnt;
    logic                    w_dma_gnt;
    logic [W_FRAME_SIZE-1:0] w_save_nxt;

    // Aux-port arbitration: lone requester wins, contention alternates.
    always_comb begin
        w_rte_req  = (r_state == S_LOAD) && (r_issue_cnt < r_frame_size);
        w_conflict = w_rte_req && dma_aux_req;
        w_save_nxt = sat_inc(r_save_cnt, pp_data_vld);
        if (w_conflict) begin
            w_rte_gnt = r_last_dma;
            w_dma_gnt = ~r_last_dma;
        end else begin
            w_rte_gnt = w_rte_req;
            w_dma_gnt = dma_aux_req;
        end
    end

    // Descriptor sequencer with registered outputs, counters and owner bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_cfg_rdy    <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_route_save <= 1'b0;
            r_route_load <= 1'b0;
            r_save_flag  <= 1'b0;
            r_load_flag  <= 1'b0;
            r_loc        <= 2'b00;
            r_offset     <= '0;
            r_frame_size <= '0;
            r_issue_cnt  <= '0;
            r_save_cnt   <= '0;
            r_last_dma   <= 1'b0;
        end else begin
            // Only contended cycles flip the turn, so solo DMA traffic
            // outside a load does not steal the route's next turn.
            if (w_conflict) begin
                r_last_dma <= w_dma_gnt;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_vld) begin
                        r_loc        <= cfg_loc;
                        r_offset     <= cfg_offset;
                        r_frame_size <= cfg_frame_size;
                        r_save_flag  <= cfg_save;
                        r_load_flag  <= cfg_load;
                        r_err        <= 1'b0;
                        r_issue_cnt  <= '0;
                        r_save_cnt   <= '0;
                        r_cfg_rdy    <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (r_loc[1]) begin
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_load_flag && (r_loc == 2'b01) &&
                                 (r_frame_size != '0)) begin
                        r_route_load <= 1'b1;
                        r_state      <= S_LOAD;
                    end else if (r_save_flag) begin
                        r_route_save <= 1'b1;
                        r_state      <= S_SAVE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_LOAD: begin
                    r_issue_cnt <= sat_inc(r_issue_cnt, w_rte_gnt);
                    if (rte_buf_load_done) begin
                        r_state <= S_LWAIT;
                    end
                end
                S_LWAIT: begin
                    // q_route_load was held this extra cycle for read latency.
                    r_route_load <= 1'b0;
                    if (r_save_flag) begin
                        r_route_save <= 1'b1;
                        r_state      <= S_SAVE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_SAVE: begin
                    r_save_cnt <= w_save_nxt;
                    if (layer_done) begin
                        if ((r_loc == 2'b01) && (w_save_nxt > SAVE_LIMIT)) begin
                            r_err <= 1'b1;
                        end
                        r_route_save <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_cfg_rdy <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_route_save <= 1'b0;
                    r_route_load <= 1'b0;
                    r_done       <= 1'b0;
                    r_busy       <= 1'b0;
                    r_cfg_rdy    <= 1'b1;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_rdy          = r_cfg_rdy;
    assign route_busy       = r_busy;
    assign route_done       = r_done;
    assign route_err        = r_err;
    assign q_route_save     = r_route_save;
    assign q_route_load     = r_route_load;
    assign q_route_loc      = r_loc;
    assign q_route_offset   = r_offset;
    assign q_frame_size     = r_frame_size;
    assign rte_buf_load_vld = w_rte_gnt;
    assign dma_aux_gnt      = w_dma_gnt;

endmodule

// File: tb/tb_route_sched.sv
// Self-checking bench for route_sched: directed vector table, hand-written
// timing/reset sequences, and randomized descriptors against a rule model.
module tb_route_sched;

    localparam int IFM_AW = 12;
    localparam int W_FS   = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_vld, cfg_rdy, cfg_save, cfg_load;
    logic [1:0]        cfg_loc;
    logic [IFM_AW-1:0] cfg_offset;
    logic [W_FS-1:0]   cfg_frame_size;
    logic              layer_done, pp_data_vld;
    logic              q_route_save, q_route_load;
    logic [1:0]        q_route_loc;
    logic [IFM_AW-1:0] q_route_offset;
    logic [W_FS-1:0]   q_frame_size;
    logic              rte_buf_load_vld, rte_buf_load_done;
    logic              dma_aux_req, dma_aux_gnt;
    logic              route_busy, route_done, route_err;

    always #5 clk = ~clk;

    route_sched #(.IFM_AW(IFM_AW), .W_FRAME_SIZE(W_FS)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_save(cfg_save), .cfg_load(cfg_load),
        .cfg_loc(cfg_loc), .cfg_offset(cfg_offset), .cfg_frame_size(cfg_frame_size),
        .layer_done(layer_done), .pp_data_vld(pp_data_vld),
        .q_route_save(q_route_save), .q_route_load(q_route_load), .q_route_loc(q_route_loc),
        .q_route_offset(q_route_offset), .q_frame_size(q_frame_size),
        .rte_buf_load_vld(rte_buf_load_vld), .rte_buf_load_done(rte_buf_load_done),
        .dma_aux_req(dma_aux_req), .dma_aux_gnt(dma_aux_gnt),
        .route_busy(route_busy), .route_done(route_done), .route_err(route_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- monitor (samples on falling edge) ----------------
    int cyc = 0;
    int m_strobes, m_dma_gnts, m_first_strobe, m_last_strobe, m_first_load;
    int m_first_save, m_last_save, m_dones, m_done_cyc, m_viol;
    bit m_load_seen, m_save_seen, m_busy_seen;

    function automatic int cur();
        return cyc + 1;
    endfunction

    task automatic clear_mon();
        m_strobes = 0; m_dma_gnts = 0; m_first_strobe = 0; m_last_strobe = 0;
        m_first_load = 0; m_first_save = 0; m_last_save = 0; m_dones = 0;
        m_done_cyc = 0; m_viol = 0; m_load_seen = 0; m_save_seen = 0; m_busy_seen = 0;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rstn) begin
            if (rte_buf_load_vld) begin
                if (m_strobes == 0) m_first_strobe = cyc;
                m_last_strobe = cyc;
                m_strobes++;
            end
            if (dma_aux_gnt) m_dma_gnts++;
            if (rte_buf_load_vld && dma_aux_gnt) m_viol++;
            if (dma_aux_gnt && !dma_aux_req) m_viol++;
            if (dma_aux_req && !rte_buf_load_vld && !dma_aux_gnt) m_viol++;
            if (rte_buf_load_vld && !q_route_load) m_viol++;
            if (route_busy == cfg_rdy) m_viol++;
            if (q_route_load) begin
                if (!m_load_seen) m_first_load = cyc;
                m_load_seen = 1;
            end
            if (q_route_save) begin
                if (!m_save_seen) m_first_save = cyc;
                m_save_seen = 1;
                m_last_save = cyc;
            end
            if (route_done) begin
                m_dones++;
                m_done_cyc = cyc;
                if (q_route_save || q_route_load) m_viol++;
            end
            if (route_busy) m_busy_seen = 1;
        end
    end

    // ---------------- reference model (descriptor-level rules) ----------------
    function automatic void model(input logic [1:0] loc, input bit ld, input bit sv,
                                  input int size, input int npp,
                                  output int es, output bit ee, output bit el, output bit esv);
        bit unsupported;
        unsupported = loc[1];
        el  = !unsupported && ld && (loc == 2'b01) && (size != 0);
        es  = el ? size : 0;
        esv = !unsupported && sv;
        ee  = unsupported || (esv && (loc == 2'b01) && (npp > 512));
    endfunction

    // ---------------- descriptor driver + per-descriptor checks ----------------
    int t_acc, t_ldone, t_lydone;

    task automatic run_desc(input string tag, input logic [1:0] loc, input bit ld, input bit sv,
                            input int size, input int dma_mode, input int npp, input bit stray,
                            input int es, input bit ee, input bit el, input bit esv);
        int  pp_sent;
        bit  done_sent, ly_sent, stray_sent, timeout;
        logic [IFM_AW-1:0] off;
        off = IFM_AW'($urandom_range(0, 4095));
        pp_sent = 0; done_sent = 0; ly_sent = 0; stray_sent = 0; timeout = 1;
        t_ldone = 0; t_lydone = 0;
        @(posedge clk); #1;
        clear_mon();
        cfg_vld = 1'b1; cfg_loc = loc; cfg_load = ld; cfg_save = sv;
        cfg_offset = off; cfg_frame_size = W_FS'(size);
        t_acc = cur();
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            cfg_vld = 1'b0; rte_buf_load_done = 1'b0; pp_data_vld = 1'b0;
            layer_done = 1'b0; dma_aux_req = 1'b0;
            if (m_dones > 0) begin
                timeout = 0;
                break;
            end
            if (stray && k == 0) begin
                // not accepted while busy
                cfg_vld = 1'b1; cfg_loc = 2'b00; cfg_frame_size = W_FS'(size + 1);
            end
            dma_aux_req = (dma_mode == 1) ? 1'b1 :
                          (dma_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (q_route_load && !done_sent && m_strobes >= size) begin
                rte_buf_load_done = 1'b1; done_sent = 1; t_ldone = cur();
            end else if (q_route_load && stray) begin
                pp_data_vld = 1'($urandom_range(0, 1));
                if (!stray_sent) begin
                    layer_done = 1'b1; stray_sent = 1;
                end
            end
            if (q_route_save) begin
                if (pp_sent < npp) begin
                    if (dma_mode != 2 || $urandom_range(0, 3) != 0) begin
                        pp_data_vld = 1'b1; pp_sent++;
                    end
                end else if (!ly_sent) begin
                    layer_done = 1'b1; ly_sent = 1; t_lydone = cur();
                end
            end
        end
        cfg_vld = 1'b0;
        check({tag, "_done_seen"}, {31'd0, ~timeout}, 32'd1);
        check({tag, "_done_count"}, m_dones, 32'd1);
        check({tag, "_strobes"}, m_strobes, es);
        check({tag, "_err"}, {31'd0, route_err}, {31'd0, ee});
        check({tag, "_load_seen"}, {31'd0, m_load_seen}, {31'd0, el});
        check({tag, "_save_seen"}, {31'd0, m_save_seen}, {31'd0, esv});
        check({tag, "_arb_viol"}, m_viol, 32'd0);
        check({tag, "_busy_seen"}, {31'd0, m_busy_seen}, 32'd1);
        check({tag, "_rdy_after"}, {31'd0, cfg_rdy}, 32'd1);
        check({tag, "_q_fields"}, {q_route_loc, q_route_offset, q_frame_size},
              {loc, off, W_FS'(size)});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0] loc;
        bit ld; bit sv;
        int size; int dma; int npp; bit stray;
        int e_strobes; bit e_err; bit e_load; bit e_save;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int es; bit ee, el, esv;
        logic [1:0] rl;
        bit rld, rsv, rst;
        int rsize, rdma, rnpp, r;

        vecs[0]  = '{2'b01, 1, 0, 4, 0,   0, 0, 4, 0, 1, 0};
        vecs[1]  = '{2'b01, 1, 0, 4, 1,   0, 0, 4, 0, 1, 0};
        vecs[2]  = '{2'b00, 1, 1, 5, 0,  10, 0, 0, 0, 0, 1};
        vecs[3]  = '{2'b10, 1, 1, 4, 0,   0, 0, 0, 1, 0, 0};
        vecs[4]  = '{2'b00, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[5]  = '{2'b01, 0, 1, 0, 0, 600, 0, 0, 1, 0, 1};
        vecs[6]  = '{2'b01, 1, 1, 3, 2, 513, 0, 3, 1, 1, 1};
        vecs[7]  = '{2'b01, 1, 1, 6, 0, 512, 1, 6, 0, 1, 1};
        vecs[8]  = '{2'b11, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0};
        vecs[9]  = '{2'b01, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[10] = '{2'b00, 0, 1, 7, 0, 600, 0, 0, 0, 0, 1};

        rstn = 1'b0; cfg_vld = 1'b0; cfg_save = 1'b0; cfg_load = 1'b0; cfg_loc = 2'b00;
        cfg_offset = '0; cfg_frame_size = '0; layer_done = 1'b0; pp_data_vld = 1'b0;
        rte_buf_load_done = 1'b0; dma_aux_req = 1'b0;
        clear_mon();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {cfg_rdy, q_route_save, q_route_load, q_route_loc, q_route_offset, q_frame_size,
               rte_buf_load_vld, dma_aux_gnt, route_busy, route_done, route_err},
              {1'b1, 1'b0, 1'b0, 2'b00, 12'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); rstn = 1'b1;

        // table
        for (int i = 0; i < 11; i++) begin
            run_desc($sformatf("vec%0d", i), vecs[i].loc, vecs[i].ld, vecs[i].sv,
                     vecs[i].size, vecs[i].dma, vecs[i].npp, vecs[i].stray,
                     vecs[i].e_strobes, vecs[i].e_err, vecs[i].e_load, vecs[i].e_save);
            if (i == 0) begin
                check("t1_first_strobe", m_first_strobe, m_first_load);
                check("t1_consecutive", m_last_strobe - m_first_strobe, 32'd3);
                check("t1_done_latency", m_done_cyc - t_ldone, 32'd2);
            end
            if (i == 1) begin
                check("t2_dma_first", m_first_strobe, m_first_load + 1);
                check("t2_alternate", m_last_strobe - m_first_strobe, 32'd6);
            end
            if (i == 2) begin
                check("t3_save_start", m_first_save, t_acc + 2);
                check("t3_save_end", m_last_save, t_lydone);
            end
            if (i == 3) begin
                check("t4_done_latency", m_done_cyc, t_acc + 2);
            end
        end

        // reset in the middle of a load
        @(posedge clk); #1;
        clear_mon();
        cfg_vld = 1'b1; cfg_loc = 2'b01; cfg_load = 1'b1; cfg_save = 1'b0; cfg_frame_size = 16'd8;
        @(posedge clk); #1;
        cfg_vld = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (m_strobes >= 2) break;
            @(posedge clk); #1;
        end
        check("t6_strobes_before_reset", m_strobes, 32'd2);
        rstn = 1'b0;
        #1;
        check("t6_reset_outputs",
              {cfg_rdy, q_route_save, q_route_load, q_frame_size, rte_buf_load_vld,
               dma_aux_gnt, route_busy, route_done, route_err},
              {1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk); rstn = 1'b1;
        check("t6_no_done_pulse", m_dones, 32'd0);
        run_desc("t6_reload", 2'b01, 1, 0, 3, 0, 0, 0, 3, 0, 1, 0);

        // randomized descriptors against the rule model
        for (int i = 0; i < 40; i++) begin
            r     = $urandom_range(0, 7);
            rl    = (r < 4) ? 2'b01 : (r < 6) ? 2'b00 : (r == 6) ? 2'b10 : 2'b11;
            rld   = 1'($urandom_range(0, 1));
            rsv   = 1'($urandom_range(0, 1));
            rsize = $urandom_range(0, 12);
            rdma  = $urandom_range(0, 2);
            rnpp  = ($urandom_range(0, 9) == 0) ? $urandom_range(505, 520) : $urandom_range(0, 20);
            rst   = 1'($urandom_range(0, 1));
            model(rl, rld, rsv, rsize, rnpp, es, ee, el, esv);
            run_desc($sformatf("rnd%0d", i), rl, rld, rsv, rsize, rdma, rnpp, rst, es, ee, el, esv);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
